// File: rtl/grant_dispatch_pkg.sv
// Shared types and helpers for the grant dispatcher: FSM state encoding,
// source index constants and the one-hot grant decoder.
package grant_dispatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_REL = 2'd2
   } state_t;

   localparam logic [1:0] SRC0 = 2'd0;
   localparam logic [1:0] SRC1 = 2'd1;
   localparam logic [1:0] SRC2 = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } onehot_t;

   // valid is set only for exactly one bit high; idx is meaningful only then
   function automatic onehot_t onehot3(input logic [2:0] g);
      onehot_t r;
      r.valid = 1'b0;
      r.idx   = SRC0;
      case (g)
         3'b001: begin r.valid = 1'b1; r.idx = SRC0; end
         3'b010: begin r.valid = 1'b1; r.idx = SRC1; end
         3'b100: begin r.valid = 1'b1; r.idx = SRC2; end
         default: begin r.valid = 1'b0; r.idx = SRC0; end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Stall watchdog: counts consecutive stalled SEND cycles and flags the
// stalled cycle that reaches TIMEOUT so the dispatcher can abort.
module dispatch_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic res_n,
   input  logic clear,
   input  logic stall,
   output logic expire
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: cleared outside SEND, saturating increment on each stall
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (stall && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // This stall is the TIMEOUT-th in a row; a ready cycle never expires
   assign expire = stall && !clear && (count_q == LIMIT);

endmodule

// File: rtl/grant_dispatch.sv
// Captures the word of the one-hot granted requester and delivers it on a
// valid/ready bus, pulsing a per-requester done or a timeout error.
module grant_dispatch #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic              grant0,
   input  logic              grant1,
   input  logic              grant2,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic              bus_ready,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic [1:0]        bus_src,
   output logic              done0,
   output logic              done1,
   output logic              done2,
   output logic              err_timeout,
   output logic              err_grant
);

   import grant_dispatch_pkg::*;

   state_t            state_q,       state_d;
   logic              bus_valid_q,   bus_valid_d;
   logic [DATA_W-1:0] bus_data_q,    bus_data_d;
   logic [1:0]        bus_src_q,     bus_src_d;
   logic [2:0]        done_q,        done_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_grant_q,   err_grant_d;

   logic [2:0]        grant_s;
   onehot_t           sel_s;
   logic [DATA_W-1:0] sel_data_s;
   logic              released_s;
   logic              wd_clear_s;
   logic              wd_stall_s;
   logic              wd_expire_s;

   assign grant_s    = {grant2, grant1, grant0};
   assign sel_s      = onehot3(grant_s);
   assign wd_clear_s = (state_q != ST_SEND);
   assign wd_stall_s = (state_q == ST_SEND) && !bus_ready;

   dispatch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .res_n  (res_n),
      .clear  (wd_clear_s),
      .stall  (wd_stall_s),
      .expire (wd_expire_s)
   );

   // Data mux for the single granted requester
   always_comb begin
      sel_data_s = data0;
      case (sel_s.idx)
         SRC1:    sel_data_s = data1;
         SRC2:    sel_data_s = data2;
         default: sel_data_s = data0;
      endcase
   end

   // Has the requester we just served dropped its grant?
   always_comb begin
      released_s = 1'b1;
      case (bus_src_q)
         SRC0:    released_s = !grant0;
         SRC1:    released_s = !grant1;
         SRC2:    released_s = !grant2;
         default: released_s = 1'b1;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      bus_valid_d   = bus_valid_q;
      bus_data_d    = bus_data_q;
      bus_src_d     = bus_src_q;
      done_d        = 3'b000;
      err_timeout_d = 1'b0;
      err_grant_d   = err_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_s.valid) begin
               bus_data_d  = sel_data_s;
               bus_src_d   = sel_s.idx;
               bus_valid_d = 1'b1;
               state_d     = ST_SEND;
            end else if (grant_s != 3'b000) begin
               err_grant_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            // Ready is checked first so a handshake on the final allowed cycle wins
            if (bus_ready) begin
               bus_valid_d = 1'b0;
               done_d      = 3'b001 << bus_src_q;
               state_d     = ST_WAIT_REL;
            end else if (wd_expire_s) begin
               bus_valid_d   = 1'b0;
               err_timeout_d = 1'b1;
               state_d       = ST_WAIT_REL;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_WAIT_REL: begin
            if (released_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_REL;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            bus_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q       <= ST_IDLE;
         bus_valid_q   <= 1'b0;
         bus_data_q    <= '0;
         bus_src_q     <= SRC0;
         done_q        <= 3'b000;
         err_timeout_q <= 1'b0;
         err_grant_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus_valid_q   <= bus_valid_d;
         bus_data_q    <= bus_data_d;
         bus_src_q     <= bus_src_d;
         done_q        <= done_d;
         err_timeout_q <= err_timeout_d;
         err_grant_q   <= err_grant_d;
      end
   end

   assign bus_valid   = bus_valid_q;
   assign bus_data    = bus_data_q;
   assign bus_src     = bus_src_q;
   assign done0       = done_q[0];
   assign done1       = done_q[1];
   assign done2       = done_q[2];
   assign err_timeout = err_timeout_q;
   assign err_grant   = err_grant_q;

endmodule

// File: tb/tb_grant_dispatch.sv
// Self-checking bench for grant_dispatch: directed scenarios plus random
// transactions checked against a transaction-level expectation model.
module tb_grant_dispatch;

   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              res_n;
   logic              grant0, grant1, grant2;
   logic [DATA_W-1:0] data0, data1, data2;
   logic              bus_ready;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic [1:0]        bus_src;
   logic              done0, done1, done2;
   logic              err_timeout;
   logic              err_grant;

   int checks   = 0;
   int failures = 0;
   logic exp_err_grant = 1'b0;

   grant_dispatch #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .res_n       (res_n),
      .grant0      (grant0),
      .grant1      (grant1),
      .grant2      (grant2),
      .data0       (data0),
      .data1       (data1),
      .data2       (data2),
      .bus_ready   (bus_ready),
      .bus_valid   (bus_valid),
      .bus_data    (bus_data),
      .bus_src     (bus_src),
      .done0       (done0),
      .done1       (done1),
      .done2       (done2),
      .err_timeout (err_timeout),
      .err_grant   (err_grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_grants(input logic [2:0] g);
      grant0 = g[0];
      grant1 = g[1];
      grant2 = g[2];
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
      chk({tag, "_data"},  32'(bus_data), 32'd0);
      chk({tag, "_src"},   32'(bus_src), 32'd0);
      chk({tag, "_done"},  32'({done2, done1, done0}), 32'd0);
      chk({tag, "_tmo"},   32'(err_timeout), 32'd0);
      chk({tag, "_egnt"},  32'(err_grant), 32'd0);
   endtask

   // One transfer: k stalled cycles before ready, grant held for hold extra
   // cycles afterwards. Expected: min(k+1, TIMEOUT) valid cycles; done if
   // k < TIMEOUT, else one err_timeout pulse. Grant is left high on return.
   task automatic txn(input int src, input logic [7:0] d, input int k,
                      input int hold, input int exp_lat);
      int  lat;
      int  vcount;
      bit  exp_ok;
      case (src)
         0: data0 = d;
         1: data1 = d;
         default: data2 = d;
      endcase
      set_grants(3'b001 << src);
      bus_ready = (k == 0);
      lat = 0;
      do begin
         step();
         lat++;
      end while (bus_valid !== 1'b1 && lat < 6);
      chk("grant_to_valid", 32'(lat), 32'(exp_lat));
      vcount = 0;
      while (bus_valid === 1'b1 && vcount < 300) begin
         vcount++;
         chk("send_data", 32'(bus_data), 32'(d));
         chk("send_src", 32'(bus_src), 32'(src));
         chk("send_done", 32'({done2, done1, done0}), 32'd0);
         chk("send_tmo", 32'(err_timeout), 32'd0);
         bus_ready = (vcount > k);
         step();
      end
      exp_ok = (k < TIMEOUT);
      chk("valid_cycles", 32'(vcount), exp_ok ? 32'(k + 1) : 32'(TIMEOUT));
      chk("done_pulse", 32'({done2, done1, done0}), exp_ok ? (32'd1 << src) : 32'd0);
      chk("tmo_pulse", 32'(err_timeout), exp_ok ? 32'd0 : 32'd1);
      bus_ready = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         step();
         chk("hold_valid", 32'(bus_valid), 32'd0);
         chk("hold_done", 32'({done2, done1, done0}), 32'd0);
         chk("hold_tmo", 32'(err_timeout), 32'd0);
      end
      chk("err_grant_level", 32'(err_grant), 32'(exp_err_grant));
   endtask

   task automatic release_grants();
      set_grants(3'b000);
      step();
   endtask

   initial begin
      int  prev_src;
      int  src;
      int  k;
      int  lat;
      bit  chained;

      res_n     = 1'b1;
      set_grants(3'b000);
      data0     = 8'h00;
      data1     = 8'h00;
      data2     = 8'h00;
      bus_ready = 1'b0;
      #2 res_n = 1'b0;
      #1;
      chk_reset_outputs("reset");
      step();
      step();
      res_n = 1'b1;
      step();
      chk_reset_outputs("post_reset_idle");

      // Basic transfer with ready high, then release
      txn(1, 8'hA5, 0, 2, 1);
      release_grants();
      // Five stalls then accept
      txn(0, 8'h3C, 5, 0, 1);
      release_grants();
      // Ready held low: abort after TIMEOUT cycles
      txn(2, 8'h5A, 100, 0, 1);
      release_grants();
      // Ready arrives on the last permitted cycle
      txn(1, 8'hC3, TIMEOUT - 1, 0, 1);
      release_grants();
      txn(0, 8'h11, TIMEOUT, 1, 1);
      release_grants();
      // grant0 held four cycles after done, then grant1 takes over directly
      txn(0, 8'h77, 0, 4, 1);
      txn(1, 8'h88, 0, 0, 2);
      release_grants();

      prev_src = -1;
      for (int n = 0; n < 30; n++) begin
         src = int'($urandom_range(2, 0));
         case ($urandom_range(3, 0))
            0:       k = 0;
            1:       k = int'($urandom_range(4, 1));
            2:       k = TIMEOUT - 2 + int'($urandom_range(3, 0));
            default: k = int'($urandom_range(20, 0));
         endcase
         chained = (prev_src >= 0) && (prev_src != src);
         lat = chained ? 2 : 1;
         if (!chained && prev_src >= 0) begin
            release_grants();
         end
         txn(src, 8'($urandom), k, int'($urandom_range(3, 0)), lat);
         prev_src = src;
      end
      release_grants();

      // Illegal grant vector in IDLE
      set_grants(3'b101);
      step();
      exp_err_grant = 1'b1;
      chk("egnt_set", 32'(err_grant), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("egnt_no_valid", 32'(bus_valid), 32'd0);
         chk("egnt_sticky", 32'(err_grant), 32'd1);
      end
      release_grants();
      chk("egnt_after_release", 32'(err_grant), 32'd1);
      txn(2, 8'h42, 0, 0, 1);
      release_grants();
      res_n = 1'b0;
      #1;
      exp_err_grant = 1'b0;
      chk("egnt_cleared", 32'(err_grant), 32'd0);
      step();
      res_n = 1'b1;
      step();

      // Reset in the middle of SEND
      data1 = 8'h96;
      set_grants(3'b010);
      bus_ready = 1'b0;
      step();
      chk("mid_send_valid", 32'(bus_valid), 32'd1);
      step();
      res_n = 1'b0;
      #1;
      chk_reset_outputs("mid_send_reset");
      set_grants(3'b000);
      step();
      res_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_abort_done", 32'({done2, done1, done0}), 32'd0);
         chk("post_abort_valid", 32'(bus_valid), 32'd0);
         chk("post_abort_tmo", 32'(err_timeout), 32'd0);
      end
      txn(0, 8'hE1, 2, 0, 1);
      release_grants();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
